// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared constants, state enum and shift codes for operand fetch
package operand_fetch_pkg;

    localparam int DW   = 16;
    localparam int NREG = 8;
    localparam int AW   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/regfile_1r1w.sv
// rtl/regfile_1r1w.sv - NREG x DW register array, one combinational read, one synchronous write
module regfile_1r1w
    import operand_fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] r_mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - sequences single-port register reads into operand latches A/B for the shifter
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_rn,
    input  logic [AW-1:0] req_rm,
    input  logic [1:0]    req_shift,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic [1:0]    op_shift,
    output logic          busy
);

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_rn;
    logic [AW-1:0] r_rm;
    logic [AW-1:0] w_rd_addr;
    logic [DW-1:0] w_rf_data;
    logic [DW-1:0] w_rd_byp;
    logic          w_accept;

    assign w_accept  = req_valid && (r_state == IDLE);
    assign w_rd_addr = (r_state == RD_B) ? r_rm : r_rn;

    // Write-first: a same-cycle writeback to the register being read wins.
    assign w_rd_byp = (wr_en && (wr_addr == w_rd_addr)) ? wr_data : w_rf_data;

    regfile_1r1w u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (w_rd_addr),
        .rd_data (w_rf_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next_state = RD_A;
            RD_A:    w_next_state = RD_B;
            RD_B:    w_next_state = OUT;
            OUT:     if (op_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rn     <= '0;
            r_rm     <= '0;
            op_shift <= SH_NONE;
            op_a     <= '0;
            op_b     <= '0;
        end else begin
            if (w_accept) begin
                r_rn     <= req_rn;
                r_rm     <= req_rm;
                op_shift <= req_shift;
            end
            if (r_state == RD_A) op_a <= w_rd_byp;
            if (r_state == RD_B) op_b <= w_rd_byp;
        end
    end

    assign req_ready = (r_state == IDLE);
    assign op_valid  = (r_state == OUT);
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - randomized self-checking bench for operand_fetch against a register-array model
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_rn = '0;
    logic [2:0]  req_rm = '0;
    logic [1:0]  req_shift = '0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [1:0]  op_shift;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] mem [8];

    operand_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rn    (req_rn),
        .req_rm    (req_rm),
        .req_shift (req_shift),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_shift  (op_shift),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One clock: drive a write, commit it to the model on the edge, return at the falling edge.
    task automatic step(input logic we, input logic [2:0] wa, input logic [15:0] wd);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        @(posedge clk);
        if (we && rst_n) mem[wa] = wd;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rand_step(input bit rnd);
        logic [2:0]  a;
        logic [15:0] d;
        a = 3'($urandom_range(0, 7));
        d = 16'($urandom);
        step(rnd && ($urandom_range(0, 1) == 1), a, d);
    endtask

    // Full request: accept, RD_A, RD_B, then OUT held for 'hold' extra cycles.
    task automatic run_req(input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh,
                           input int hold, input bit rnd, input bit byp_en,
                           input logic [15:0] byp_data, input bit out_wr_en,
                           input logic [15:0] out_wr_data);
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL req_ready_idle: got %b want 1", req_ready);
        end
        req_valid = 1'b1;
        req_rn    = rn;
        req_rm    = rm;
        req_shift = sh;
        rand_step(rnd);
        req_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        req_rn    = 3'($urandom);
        req_rm    = 3'($urandom);
        req_shift = 2'($urandom);
        n_checks++;
        if (op_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL rd_a_flags: got valid=%b busy=%b ready=%b want 0 1 0", op_valid, busy, req_ready);
        end
        if (byp_en) step(1'b1, rn, byp_data);
        else rand_step(rnd);
        exp_a = mem[rn];
        n_checks++;
        if (op_valid !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL rd_b_flags: got valid=%b busy=%b want 0 1", op_valid, busy);
        end
        rand_step(rnd);
        exp_b = mem[rm];
        for (int k = 0; k <= hold; k++) begin
            n_checks++;
            if (op_valid !== 1'b1 || op_a !== exp_a || op_b !== exp_b || op_shift !== sh ||
                req_ready !== 1'b0 || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL out_cycle%0d: got v=%b a=%h b=%h sh=%b rdy=%b busy=%b want 1 %h %h %b 0 1",
                         k, op_valid, op_a, op_b, op_shift, req_ready, busy, exp_a, exp_b, sh);
            end
            op_ready = (k == hold);
            if (out_wr_en && k == 0) step(1'b1, rn, out_wr_data);
            else rand_step(rnd);
            op_ready = 1'b0;
        end
        req_valid = 1'b0;
        n_checks++;
        if (op_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL after_handshake: got v=%b rdy=%b busy=%b want 0 1 0", op_valid, req_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || op_valid !== 1'b0 || busy !== 1'b0 ||
            op_a !== 16'h0 || op_b !== 16'h0 || op_shift !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_state: got rdy=%b v=%b busy=%b a=%h b=%h sh=%b want 1 0 0 0 0 0",
                     req_ready, op_valid, busy, op_a, op_b, op_shift);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_req(3'd0, 3'd1, 2'b00, 0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        run_req(3'd6, 3'd7, 2'b00, 0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic test_basic();
        step(1'b1, 3'd3, 16'h00A5);
        step(1'b1, 3'd5, 16'h8001);
        run_req(3'd3, 3'd5, 2'b11, 0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        n_checks++;
        if (op_a !== 16'h00A5 || op_b !== 16'h8001) begin
            n_errors++;
            $display("FAIL basic_operands: got a=%h b=%h want 00a5 8001", op_a, op_b);
        end
    endtask

    task automatic test_backpressure();
        run_req(3'd3, 3'd5, 2'b11, 5, 1'b0, 1'b0, 16'h0, 1'b1, 16'hFFFF);
        run_req(3'd3, 3'd5, 2'b01, 0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        n_checks++;
        if (op_a !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL backpressure_write_landed: got a=%h want ffff", op_a);
        end
    endtask

    task automatic test_bypass();
        step(1'b1, 3'd2, 16'h0011);
        run_req(3'd2, 3'd5, 2'b10, 0, 1'b0, 1'b1, 16'h0BEE, 1'b0, 16'h0);
        n_checks++;
        if (op_a !== 16'h0BEE) begin
            n_errors++;
            $display("FAIL bypass_a: got %h want 0bee", op_a);
        end
        run_req(3'd2, 3'd2, 2'b00, 0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic test_back_to_back();
        step(1'b1, 3'd7, 16'h1234);
        run_req(3'd7, 3'd7, 2'b01, 0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        n_checks++;
        if (op_a !== 16'h1234 || op_b !== 16'h1234) begin
            n_errors++;
            $display("FAIL same_reg: got a=%h b=%h want 1234 1234", op_a, op_b);
        end
        run_req(3'd7, 3'd3, 2'b10, 1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            run_req(3'($urandom), 3'($urandom), 2'($urandom), $urandom_range(0, 3),
                    1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
            if ($urandom_range(0, 1) == 1) rand_step(1'b1);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 3'd4, 16'hA5A5);
        req_valid = 1'b1;
        req_rn    = 3'd4;
        req_rm    = 3'd4;
        req_shift = 2'b11;
        step(1'b0, 3'd0, 16'h0);
        req_valid = 1'b0;
        step(1'b0, 3'd0, 16'h0);
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        #1;
        n_checks++;
        if (op_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_reset_async: got v=%b busy=%b rdy=%b want 0 0 1", op_valid, busy, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 3'd0, 16'h0);
            n_checks++;
            if (op_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL post_reset_idle%0d: got v=%b rdy=%b want 0 1", c, op_valid, req_ready);
            end
        end
        for (int r = 0; r < 8; r += 2) begin
            run_req(3'(r), 3'(r + 1), 2'b00, 0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
            n_checks++;
            if (op_a !== 16'h0 || op_b !== 16'h0) begin
                n_errors++;
                $display("FAIL regs_cleared_r%0d: got a=%h b=%h want 0 0", r, op_a, op_b);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_bypass();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage directly upstream of the datapath shifter. Holds the 8-entry general register file and sequences single-read-port accesses to load operand latches A and B. Presents {A, B, shift code} to the shifter/ALU stage through a valid/ready handshake. Accepts writeback from the end of the datapath on every cycle.

## Interface
- DW, 16, register and operand width
- NREG, 8, number of registers (address width AW = 3)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset: asynchronous assert, active-low
- req_valid  in  1  fetch request present
- req_ready  out  1  stage can accept a request
- req_rn  in  AW  register index for operand A
- req_rm  in  AW  register index for operand B
- req_shift  in  2  shift code forwarded to shifter
- wr_en  in  1  writeback enable
- wr_addr  in  AW  writeback register index
- wr_data  in  DW  writeback data
- op_valid  out  1  operands valid for downstream
- op_ready  in  1  downstream accepts operands
- op_a  out  DW  operand A
- op_b  out  DW  operand B, drives shifter input
- op_shift  out  2  latched shift code: 00 pass, 01 LSL1, 10 LSR1, 11 ASR1
- busy  out  1  state != IDLE

## Operation
- Reset, while rst_n low: all NREG registers, op_a, op_b and op_shift = 0; state IDLE; op_valid = 0; busy = 0.
- req_ready = (state == IDLE). It is Moore-decoded and reads 1 during reset, but no capture occurs while rst_n is low.
- The FSM has four states:
  - IDLE: on req_valid && req_ready, capture rn, rm and shift; go to RD_A.
  - RD_A: op_a <= R[rn] with bypass; go to RD_B.
  - RD_B: op_b <= R[rm] with bypass; go to OUT.
  - OUT: op_valid = 1; op_a, op_b and op_shift hold stable; on op_ready go to IDLE.
- Single read port: exactly one register read per cycle, in RD_A or RD_B only.
- Bypass rule: if wr_en && wr_addr equals the index being read in the same cycle, the latch takes wr_data (write-first).
- Writeback is independent of the FSM: R[wr_addr] <= wr_data on every cycle with wr_en, in any state.
- Operand snapshot: once latched, op_a and op_b are not updated by later writes, including during OUT.
- rn == rm is legal; both latches read the same register.
- There is no hardwired zero register; R0 is writable.
- op_shift is passed through unchanged. This stage performs no shifting or arithmetic.

## Timing
- Request accepted in cycle 0 (IDLE). RD_A runs in cycle 1, RD_B in cycle 2.
- op_valid is first high in cycle 3, i.e. three cycles after acceptance.
- op_valid stays high and outputs stay stable until a cycle with op_ready = 1. The next cycle is IDLE with op_valid = 0.
- A request can be accepted no earlier than one cycle after the OUT handshake. Peak throughput is one request per 4 cycles.
- req_valid while not IDLE is ignored; the requester must hold the request until it sees req_ready.
- Write latency: a write in cycle n is visible to an ordinary read in cycle n+1. A read in cycle n sees it via the bypass.
- If rst_n asserts mid-sequence, the FSM returns to IDLE immediately, op_valid drops asynchronously, and any in-flight request is discarded.

## Structure
- Shared package holds: DW, NREG and AW constants; the state enum {IDLE, RD_A, RD_B, OUT}; and shift-code constants SH_NONE, SH_LSL, SH_LSR, SH_ASR, which the shifter also uses.
- Sub-module regfile_1r1w holds the NREG x DW array with asynchronous reset, one combinational read port and one synchronous write port.
- The bypass mux, FSM and operand latches live in operand_fetch.

## Test plan
- Reset then write R3 = 16'h00A5 and R5 = 16'h8001. Request rn = 3, rm = 5, shift = 11 with op_ready = 1. Required: op_valid in cycle 3 with op_a = 00A5, op_b = 8001, op_shift = 11.
- Backpressure: same request with op_ready = 0 for 5 cycles. op_valid and operands must hold stable, req_ready = 0 throughout, and a write R3 = FFFF during OUT must leave op_a = 00A5.
- Bypass: request rn = 2 with R2 = 0011, and drive wr_en, wr_addr = 2, wr_data = 0BEE in the RD_A cycle. Required: op_a = 0BEE, and R2 reads 0BEE afterwards.
- rn = rm = 7 with R7 = 1234: op_a = op_b = 1234. A second request issued the cycle after the handshake is accepted and produces op_valid 3 cycles later.
- Pulse rst_n low during RD_B. Required: op_valid = 0, busy = 0, all registers 0, req_ready = 1 after release, and no op_valid until a new request is accepted.
